// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - RV32I data-memory responder with programmable access latency
//
// Purpose:
//   Memory-side end of the load/store unit interface. Accepts one request at a
//   time, waits LATENCY cycles, performs the byte/half/word access against an
//   internal array, then presents a response until the initiator takes it.
//
// Ports:
//   clk_i        - clock, rising edge
//   rstn_i       - asynchronous active-low reset
//   req_valid_i  - request present
//   req_ready_o  - block can accept a request (IDLE only)
//   req_we_i     - 1 = store, 0 = load
//   req_funct3_i - RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   req_addr_i   - byte address
//   req_wdata_i  - store data, right-aligned
//   rsp_valid_o  - response present
//   rsp_ready_i  - initiator accepts the response
//   rsp_rdata_o  - extended load data; 0 for stores and errors
//   rsp_err_o    - misaligned, out of range, or illegal funct3

module data_mem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int         AW     = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        ready_q;
  logic        valid_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [0:MEM_WORDS-1];

  // Access decode. In IDLE the request is taken straight from the inputs so a
  // zero-latency access can execute on the accept edge itself; otherwise the
  // latched copy is used.
  logic        cur_we;
  logic [2:0]  cur_f3;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [AW-1:0] idx;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_data;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        f3_bad;
  logic        misalign;
  logic        out_of_range;
  logic        acc_err;
  logic [31:0] rsp_data;
  logic        accept;
  logic        access_now;
  logic        mem_we;

  always_comb begin
    cur_we    = (state == IDLE) ? req_we_i     : we_q;
    cur_f3    = (state == IDLE) ? req_funct3_i : f3_q;
    cur_addr  = (state == IDLE) ? req_addr_i   : addr_q;
    cur_wdata = (state == IDLE) ? req_wdata_i  : wdata_q;

    idx     = cur_addr[AW+1:2];
    rd_word = mem[idx];
    rd_byte = rd_word[{cur_addr[1:0], 3'b000} +: 8];
    rd_half = cur_addr[1] ? rd_word[31:16] : rd_word[15:0];

    // funct3[2] selects zero-extension for loads
    case (cur_f3[1:0])
      2'b00:   ld_data = {{24{~cur_f3[2] & rd_byte[7]}}, rd_byte};
      2'b01:   ld_data = {{16{~cur_f3[2] & rd_half[15]}}, rd_half};
      default: ld_data = rd_word;
    endcase

    // Store data is replicated across lanes; byte enables pick the lane(s).
    case (cur_f3[1:0])
      2'b00: begin
        wr_be   = 4'b0001 << cur_addr[1:0];
        wr_data = {4{cur_wdata[7:0]}};
      end
      2'b01: begin
        wr_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{cur_wdata[15:0]}};
      end
      2'b10: begin
        wr_be   = 4'b1111;
        wr_data = cur_wdata;
      end
      default: begin
        wr_be   = 4'b0000;
        wr_data = cur_wdata;
      end
    endcase

    // Loads: 011, 110, 111 illegal. Stores: anything but 000/001/010 illegal.
    if (cur_we)
      f3_bad = cur_f3[2] | (cur_f3[1:0] == 2'b11);
    else
      f3_bad = (cur_f3[1:0] == 2'b11) | (cur_f3 == 3'b110);

    misalign     = ((cur_f3[1:0] == 2'b01) & cur_addr[0]) |
                   ((cur_f3[1:0] == 2'b10) & (cur_addr[1:0] != 2'b00));
    out_of_range = (cur_addr >> (AW + 2)) != 32'd0;
    acc_err      = f3_bad | misalign | out_of_range;

    rsp_data = (acc_err | cur_we) ? 32'd0 : ld_data;

    accept     = req_valid_i & ready_q;
    access_now = ((state == IDLE) & accept & (LATENCY == 0)) |
                 ((state == WAIT) & (cnt == 4'd0));
    // rstn_i gate keeps a request seen while reset is held from touching the array
    mem_we     = rstn_i & access_now & cur_we & ~acc_err;
  end

  // Backing array: never reset, per-lane write enables
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we_i;
            f3_q    <= req_funct3_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            ready_q <= 1'b0;
            if (LATENCY == 0) begin
              state   <= RESP;
              valid_q <= 1'b1;
              rdata_q <= rsp_data;
              err_q   <= acc_err;
            end else begin
              state <= WAIT;
              cnt   <= LAT_M1;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state   <= RESP;
            valid_q <= 1'b1;
            rdata_q <= rsp_data;
            err_q   <= acc_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // Outputs stay frozen until the initiator takes the response
          if (rsp_ready_i) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder for the RV32I core's load/store unit. The core is the initiator; this block is the memory-side end of that interface.
- Accepts one load or store request at a time through a valid/ready handshake.
- Waits a programmable access latency, then performs the sub-word access with RV32I byte/half/word semantics.
- Returns a response (load data or store acknowledge, plus an error flag) through a second valid/ready handshake.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the backing array; must be a power of two.
- LATENCY, 2, extra wait cycles between request accept and response valid; legal range 0..15.

Ports:
- clk_i, input, 1, clock; all state updates on the rising edge.
- rstn_i, input, 1, asynchronous active-low reset.
- req_valid_i, input, 1, request present.
- req_ready_o, output, 1, block can accept a request.
- req_we_i, input, 1, 1 = store, 0 = load.
- req_funct3_i, input, 3, RV32I funct3: LB/LH/LW/LBU/LHU or SB/SH/SW.
- req_addr_i, input, 32, byte address.
- req_wdata_i, input, 32, store data, right-aligned.
- rsp_valid_o, output, 1, response present.
- rsp_ready_i, input, 1, initiator accepts the response.
- rsp_rdata_o, output, 32, load result, extended to 32 bits; 0 for stores and errors.
- rsp_err_o, output, 1, request was misaligned, out of range, or had an illegal funct3.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE, counter = 0, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, req_ready_o = 1 once reset is released.
  - The memory array is not reset.
- States:
  - IDLE: req_ready_o = 1. A request is accepted when req_valid_i && req_ready_o; we, funct3, addr and wdata are latched. Next state is WAIT if LATENCY > 0, else RESP.
  - WAIT: req_ready_o = 0. The counter loads LATENCY-1 on entry and decrements each cycle. When it reaches 0, the access executes and the state moves to RESP.
  - RESP: rsp_valid_o = 1. rsp_rdata_o and rsp_err_o hold stable until rsp_ready_i is sampled high. On that handshake the state returns to IDLE and rsp_valid_o drops in the next cycle.
- Latency: the response is valid exactly LATENCY+1 cycles after the accept edge. Back-to-back throughput is one request per LATENCY+2 cycles when rsp_ready_i is held high.
- Only one request is outstanding; there is no request or response queue. req_ready_o is low in WAIT and RESP.
- Access executes on the WAIT→RESP or IDLE→RESP transition:
  - Word index = addr[$clog2(MEM_WORDS)+1:2].
  - Load byte select = addr[1:0]; LB sign-extends, LBU zero-extends.
  - Load half select = addr[1]; LH sign-extends, LHU zero-extends.
  - LW returns the full word.
  - SB writes one lane (addr[1:0]) with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
  - SW writes all four lanes. Unwritten lanes are preserved.
- Error conditions: rsp_err_o = 1, no array write, rsp_rdata_o = 0, when any of:
  - halfword access with addr[0] != 0;
  - word access with addr[1:0] != 0;
  - addr[31:$clog2(MEM_WORDS)+2] != 0;
  - load funct3 in {011, 110, 111};
  - store funct3 not in {000, 001, 010}.
- Stores: rsp_rdata_o = 0, rsp_err_o = 0 on success.
- Backpressure: if rsp_ready_i is held low indefinitely, the block stays in RESP with outputs frozen. New req_valid_i is ignored (not accepted).
- req_valid_i asserted in the same cycle as the RESP handshake is not accepted that cycle; it is accepted next cycle in IDLE.
- A load following a store to the same address returns the stored data, since the store has committed before its response.
- Reset asserted in WAIT: the pending store is dropped (no array write) and the state goes to IDLE. Reset asserted in RESP: the response is lost and rsp_valid_o falls immediately (asynchronously).
- Inputs other than req_valid_i are don't-care when no handshake occurs.

Test Plan:
- LATENCY=2: SW addr 0x10, wdata 0xDEADBEEF, rsp_ready=1 → rsp_valid 3 cycles after accept, err=0. Then LW 0x10 → rdata 0xDEADBEEF.
- After word 0x10 = 0xDEADBEEF:
  - LB 0x13 → 0xFFFFFFDE;
  - LBU 0x13 → 0x000000DE;
  - LH 0x10 → 0xFFFFBEEF;
  - LHU 0x12 → 0x0000DEAD.
- SB 0x11, wdata 0x55 then LW 0x10 → 0xDEAD55EF. SH 0x12, wdata 0x1234 then LW 0x10 → 0x123455EF.
- Error cases, each with err=1, rdata=0, and no array change:
  - LW 0x22;
  - SH 0x21;
  - SW at byte address 4*MEM_WORDS;
  - load funct3 011.
- Backpressure: hold rsp_ready=0 for 5 cycles with req_valid=1 → rsp outputs stable, req_ready=0, no second accept. Release → handshake, next request accepted one cycle later.
- Reset mid-WAIT: issue SW 0x40, wdata 0xAAAA5555, assert rstn_i low during WAIT → rsp_valid=0 immediately. Then LW 0x40 → returns the previous contents (0x00000000 if preloaded to zero). Repeat with LATENCY=0 → response valid the cycle after accept.
